// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC owner and fetch-group request sequencer for the icache
module fetch_sequencer #(
    parameter int FETCH_WIDTH = 4,
    parameter int PC_W        = 16,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter int ICACHE_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PC_W-1:0]             jump_target,
    input  logic                        is_jump,
    input  logic [2:0]                  num_fetch,
    output logic [FETCH_WIDTH*PC_W-1:0] pc_to_icache_flat,
    output logic                        req_valid,
    output logic [FETCH_WIDTH-1:0]      req_mask,
    output logic                        rsp_valid,
    output logic [FETCH_WIDTH-1:0]      rsp_mask,
    output logic [PC_W-1:0]             rsp_pc,
    output logic [15:0]                 stall_cycles
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t                        state, state_next;
    logic [PC_W-1:0]               pc, pc_next;
    logic                          epoch, epoch_next;
    logic [FETCH_WIDTH*PC_W-1:0]   flat_next;
    logic                          req_valid_next;
    logic [FETCH_WIDTH-1:0]        req_mask_next;
    logic [15:0]                   stall_next;
    logic                          rsp_valid_next;
    logic [FETCH_WIDTH-1:0]        rsp_mask_next;
    logic [PC_W-1:0]               rsp_pc_next;
    logic                          issue;
    logic                          flush_pipe;
    logic [2:0]                    n_lanes;
    logic [FETCH_WIDTH-1:0]        lane_mask;

    // In-flight groups, entry 0 is the youngest; the last entry feeds rsp_*.
    logic                   pipe_valid [ICACHE_LAT];
    logic [FETCH_WIDTH-1:0] pipe_mask  [ICACHE_LAT];
    logic [PC_W-1:0]        pipe_pc    [ICACHE_LAT];
    logic                   pipe_epoch [ICACHE_LAT];

    always_comb begin
        n_lanes   = (num_fetch > 3'd4) ? 3'd4 : num_fetch;
        lane_mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_mask[FETCH_WIDTH-1-i] = (i < int'(n_lanes));
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        epoch_next     = epoch;
        flat_next      = pc_to_icache_flat;
        req_valid_next = 1'b0;
        req_mask_next  = '0;
        stall_next     = stall_cycles;
        issue          = 1'b0;
        flush_pipe     = 1'b0;

        if (is_jump) begin
            pc_next    = jump_target & ~PC_W'(1);
            epoch_next = ~epoch;
            flush_pipe = 1'b1;
            state_next = FLUSH;
        end else begin
            case (state)
                BOOT:  state_next = RUN;
                FLUSH: state_next = RUN;
                RUN: begin
                    if (n_lanes != 3'd0) begin
                        issue          = 1'b1;
                        req_valid_next = 1'b1;
                        req_mask_next  = lane_mask;
                        for (int i = 0; i < FETCH_WIDTH; i++) begin
                            flat_next[(FETCH_WIDTH-i)*PC_W-1 -: PC_W] = pc + PC_W'(2 * i);
                        end
                        pc_next = pc + PC_W'({n_lanes, 1'b0});
                    end else if (stall_cycles != 16'hFFFF) begin
                        stall_next = stall_cycles + 16'd1;
                    end
                end
                default: state_next = BOOT;
            endcase
        end
    end

    // A redirect on the presenting edge squashes the response along with the pipe.
    always_comb begin
        rsp_valid_next = pipe_valid[ICACHE_LAT-1] && (pipe_epoch[ICACHE_LAT-1] == epoch) && !is_jump;
        rsp_mask_next  = rsp_valid_next ? pipe_mask[ICACHE_LAT-1] : '0;
        rsp_pc_next    = rsp_valid_next ? pipe_pc[ICACHE_LAT-1]   : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc                <= RESET_PC;
            epoch             <= 1'b0;
            pc_to_icache_flat <= '0;
            req_valid         <= 1'b0;
            req_mask          <= '0;
            rsp_valid         <= 1'b0;
            rsp_mask          <= '0;
            rsp_pc            <= '0;
            stall_cycles      <= '0;
            for (int i = 0; i < ICACHE_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_mask[i]  <= '0;
                pipe_pc[i]    <= '0;
                pipe_epoch[i] <= 1'b0;
            end
        end else begin
            pc                <= pc_next;
            epoch             <= epoch_next;
            pc_to_icache_flat <= flat_next;
            req_valid         <= req_valid_next;
            req_mask          <= req_mask_next;
            rsp_valid         <= rsp_valid_next;
            rsp_mask          <= rsp_mask_next;
            rsp_pc            <= rsp_pc_next;
            stall_cycles      <= stall_next;
            pipe_valid[0]     <= issue && !flush_pipe;
            pipe_mask[0]      <= req_mask_next;
            pipe_pc[0]        <= pc;
            pipe_epoch[0]     <= epoch;
            for (int i = 1; i < ICACHE_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1] && !flush_pipe;
                pipe_mask[i]  <= pipe_mask[i-1];
                pipe_pc[i]    <= pipe_pc[i-1];
                pipe_epoch[i] <= pipe_epoch[i-1];
            end
        end
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the fetch PC and sequences fetch-group requests into the instruction cache for the 4-wide fetch/decode stage. Each cycle it decides whether to issue a group, using free instruction-buffer slots and branch-unit redirects. It tracks in-flight groups through the icache latency and tags each returning group valid or squashed. Downstream decode consumes rsp_valid/rsp_mask alongside the icache instruction data.

Parameters:
FETCH_WIDTH, 4, lanes per fetch group (fixed at 4 for this revision)
PC_W, 16, PC width in bits
RESET_PC, 16'h0000, PC of first group after reset
ICACHE_LAT, 1, icache request-to-data latency in cycles (1..3)

Ports:
clk  input  1  clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
jump_target  input  16  branch-unit redirect PC
is_jump  input  1  redirect strobe, valid for one cycle
num_fetch  input  3  free instruction-buffer slots (values >4 treated as 4)
pc_to_icache_flat  output  64  lane PCs; lane0 in [63:48], lane3 in [15:0]
req_valid  output  1  pc_to_icache_flat carries a live request
req_mask  output  4  live lanes of request; lane0 = bit3
rsp_valid  output  1  icache data this cycle belongs to a live, unsquashed group
rsp_mask  output  4  live lanes of returning group; lane0 = bit3
rsp_pc  output  16  base PC of returning group
stall_cycles  output  16  saturating count of RUN-state cycles with num_fetch==0

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; state=BOOT; pc_to_icache_flat=0; req_valid=0; req_mask=0; rsp_valid=0; rsp_mask=0; rsp_pc=0; stall_cycles=0; epoch=0; all in-flight pipeline entries invalid.
- Reset asserted mid-operation clears everything above immediately. In-flight groups are never reported.
- States:
  - BOOT: first edge after release, no issue. Next state is RUN.
  - RUN: normal issue.
  - FLUSH: one bubble after a redirect, no issue. Next state is RUN.
- Issue in RUN when is_jump=0 and n=min(num_fetch,4)>0:
  - Lane i PC = pc+2*i for all 4 lanes, mod 2^16.
  - req_valid=1.
  - req_mask lanes 0..n-1 are set.
  - pc advances by 2*n, wrapping mod 2^16.
- No issue in RUN when num_fetch==0: req_valid=0, pc holds, pc_to_icache_flat holds its last value, and stall_cycles increments, saturating at 16'hFFFF.
- Redirect (is_jump=1, any state except reset), which has priority over issue and stall:
  - pc = {jump_target[15:1],1'b0}.
  - epoch toggles.
  - All in-flight entries are invalidated.
  - req_valid=0 and the state goes to FLUSH.
  - The first group at the target is issued on the edge after FLUSH, if num_fetch>0.
  - A jump arriving during FLUSH re-applies the redirect and stays in FLUSH.
- In-flight tracking is a shift pipeline of depth ICACHE_LAT. Each entry holds valid, mask, base pc and epoch.
  - A group issued on edge N is presented on rsp_* after edge N+ICACHE_LAT.
  - rsp_valid=1 only if the entry is valid and its epoch matches the current epoch.
  - Otherwise rsp_valid=0, and rsp_mask/rsp_pc are don't-care but driven 0.
- A redirect on the same edge that a response would be presented squashes that response: rsp_valid=0 after that edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset release, num_fetch=4 steady: edge1 BOOT with req_valid=0; edge2 gives pc_to_icache_flat=0000_0002_0004_0006 and mask 1111; edge3 gives 0008.., and rsp_valid=1 with rsp_pc=0000 (ICACHE_LAT=1).
2. pc=0x0010, num_fetch=3: request {0010,0012,0014,0016}, req_mask=1110; next group base 0x0016.
3. num_fetch=0 for 5 RUN cycles: req_valid=0, pc and pc_to_icache_flat held, stall_cycles=5. Preload 16'hFFFE plus 3 more stall cycles: stall_cycles saturates at FFFF.
4. is_jump=1 with jump_target=0x0041 while a group is in flight: that group is presented with rsp_valid=0; next edge FLUSH with req_valid=0; then request base 0x0040, mask 1111.
5. Back-to-back is_jump (0x0100 then 0x0200): only 0x0200 is fetched, and no response for the 0x0100 path ever asserts rsp_valid.
6. pc=0xFFFC, num_fetch=4: lanes {FFFC,FFFE,0000,0002}; next base 0x0004. Also assert rst_n low mid-stream: all outputs 0 immediately, restart from RESET_PC.
